// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB-first, parity, stop(1).
// Delivers the word with parity/framing flags and counts bad frames (saturating).
module parity_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
  localparam logic PAR_REF = (PARITY_ODD != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [BC_W-1:0]   bcnt;
  logic              acc;
  logic              perr_q;

  logic stop_bad;
  assign stop_bad = ~bit_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bcnt       <= '0;
      acc        <= 1'b0;
      perr_q     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      err_count  <= '0;
    end else begin
      data_valid <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              shreg <= '0;
              bcnt  <= '0;
              acc   <= 1'b0;
              state <= DATA;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            // Shift right so the first data bit ends up at bit 0.
            shreg <= {bit_in, shreg[DATA_W-1:1]};
            acc   <= acc ^ bit_in;
            bcnt  <= bcnt + 1'b1;
            if (bcnt == LAST_BIT) state <= PARITY;
          end
          PARITY: begin
            perr_q <= (acc ^ bit_in) != PAR_REF;
            state  <= STOP;
          end
          STOP: begin
            data_out   <= shreg;
            parity_err <= perr_q;
            frame_err  <= stop_bad;
            data_valid <= 1'b1;
            if ((perr_q | stop_bad) && (err_count != {CNT_W{1'b1}}))
              err_count <= err_count + 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: table of frames plus hand sequences, checked via
// an expected/observed scoreboard; a CNT_W=2 twin exercises counter saturation.
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b1;

  logic [7:0] data_out,   data_out_s;
  logic       data_valid, data_valid_s;
  logic       parity_err, parity_err_s;
  logic       frame_err,  frame_err_s;
  logic       busy,       busy_s;
  logic [7:0] err_count;
  logic [1:0] err_count_s;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy), .err_count(err_count)
  );

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .data_out(data_out_s), .data_valid(data_valid_s), .parity_err(parity_err_s),
    .frame_err(frame_err_s), .busy(busy_s), .err_count(err_count_s)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic [7:0] cnt;
    logic [1:0] cnt_s;
  } res_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    res_t       exp;
  } vec_t;

  res_t expq[$];
  res_t obsq[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   dv_long = 0;
  logic dv_q = 1'b0;

  // Observer only: records each completed frame and any over-long data_valid.
  always @(negedge clk) begin
    if (data_valid)
      obsq.push_back({data_out, parity_err, frame_err, err_count, err_count_s});
    if (data_valid && dv_q) dv_long++;
    dv_q = data_valid;
  end

  function automatic res_t mk(input logic [7:0] d, input logic pe, input logic fe,
                              input logic [7:0] c, input logic [1:0] cs);
    res_t r;
    r.data = d; r.perr = pe; r.ferr = fe; r.cnt = c; r.cnt_s = cs;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic put_bit(input logic b, input int gap);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    bit_in    = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic stop, input int gap);
    put_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) put_bit(d[i], gap);
    put_bit(par, gap);
    put_bit(stop, gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expq.delete();
    obsq.delete();
  endtask

  task automatic drain(input string tag);
    res_t e, o;
    int   n = 0;
    while (obsq.size() < expq.size() && n < 40) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".frames"}, obsq.size(), expq.size());
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front();
      o = obsq.pop_front();
      check({tag, ".data"},  o.data,  e.data);
      check({tag, ".perr"},  o.perr,  e.perr);
      check({tag, ".ferr"},  o.ferr,  e.ferr);
      check({tag, ".cnt"},   o.cnt,   e.cnt);
      check({tag, ".cnt_s"}, o.cnt_s, e.cnt_s);
    end
    expq.delete();
    obsq.delete();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, mk(8'hA5, 1'b0, 1'b0, 8'd0, 2'd0)};
    vecs[1] = '{8'h07, 1'b0, 1'b1, mk(8'h07, 1'b1, 1'b0, 8'd1, 2'd1)};
    vecs[2] = '{8'h07, 1'b1, 1'b1, mk(8'h07, 1'b0, 1'b0, 8'd1, 2'd1)};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, mk(8'h3C, 1'b0, 1'b1, 8'd2, 2'd2)};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, mk(8'hFF, 1'b0, 1'b0, 8'd2, 2'd2)};
    vecs[5] = '{8'h01, 1'b0, 1'b0, mk(8'h01, 1'b1, 1'b1, 8'd3, 2'd3)};
    vecs[6] = '{8'h80, 1'b1, 1'b1, mk(8'h80, 1'b0, 1'b0, 8'd3, 2'd3)};
    vecs[7] = '{8'h00, 1'b1, 1'b1, mk(8'h00, 1'b1, 1'b0, 8'd4, 2'd3)};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.data_out",   data_out,   8'h00);
    check("rst.data_valid", data_valid, 1'b0);
    check("rst.parity_err", parity_err, 1'b0);
    check("rst.frame_err",  frame_err,  1'b0);
    check("rst.busy",       busy,       1'b0);
    check("rst.err_count",  err_count,  8'h00);
    rst = 1'b0;

    // Latency and single-cycle data_valid
    expq.push_back(mk(8'hA5, 1'b0, 1'b0, 8'd0, 2'd0));
    send(8'hA5, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("lat.dv_high",  data_valid, 1'b1);
    check("lat.data_out", data_out,   8'hA5);
    check("lat.busy",     busy,       1'b0);
    @(negedge clk);
    check("lat.dv_low",   data_valid, 1'b0);
    @(posedge clk); #1;
    drain("lat");

    // Table of back-to-back frames with continuous bit_valid
    do_reset();
    for (int i = 0; i < 8; i++) begin
      expq.push_back(vecs[i].exp);
      send(vecs[i].data, vecs[i].par, vecs[i].stop, 0);
    end
    drain("tbl");

    // Idle line with gapped strobes, then a gapped frame
    for (int i = 0; i < 20; i++) begin
      put_bit(1'b1, 2);
      check("idle.busy", busy, 1'b0);
    end
    expq.push_back(mk(8'hA5, 1'b0, 1'b0, 8'd4, 2'd3));
    send(8'hA5, 1'b0, 1'b1, 2);
    drain("gap");

    // Reset in the middle of a frame
    put_bit(1'b0, 0);
    put_bit(1'b0, 0);
    put_bit(1'b1, 0);
    put_bit(1'b0, 0);
    put_bit(1'b1, 0);
    check("mid.busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("arst.data_out",   data_out,   8'h00);
    check("arst.parity_err", parity_err, 1'b0);
    check("arst.busy",       busy,       1'b0);
    check("arst.err_count",  err_count,  8'h00);
    check("arst.err_count_s", err_count_s, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    obsq.delete();
    expq.push_back(mk(8'h5A, 1'b0, 1'b0, 8'd0, 2'd0));
    send(8'h5A, 1'b0, 1'b1, 0);
    drain("after_rst");

    // Saturation of the narrow counter with back-to-back bad frames
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      expq.push_back(mk(8'h01, 1'b1, 1'b0, 8'(i), (i > 3) ? 2'd3 : 2'(i)));
      send(8'h01, 1'b0, 1'b1, 0);
    end
    drain("sat");

    check("dv_single_cycle", dv_long, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
